// File: rtl/dsi_lane_feeder.sv
// Byte-stream feeder for one DSI PHY lane: packet FIFO plus start/stream/finish
// sequencing toward the lane, with inter-packet gap timing and flush on lane loss.
module dsi_lane_feeder #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_lp,
  output logic       s_ready,
  output logic       lane_start_rqst,
  output logic       lane_fin_rqst,
  output logic       lane_mode_lp,
  output logic [7:0] lane_data,
  input  logic       lane_data_rqst,
  input  logic       lane_active,
  input  logic       lane_ready,
  input  logic [7:0] inter_pkt_gap,
  input  logic       underflow_clr,
  output logic       busy,
  output logic       underflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned GAP_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_FIN    = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;
  localparam logic [2:0] ST_FLUSH  = 3'd6;

  typedef struct packed {
    logic       lp;
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  fifo_entry_t            mem_q [DEPTH];
  fifo_entry_t            wr_entry;
  fifo_entry_t            head;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       pkt_count_q, pkt_count_d;
  logic [2:0]             state_q, state_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic                   seen_active_q, seen_active_d;
  logic                   mode_lp_q, mode_lp_d;
  logic                   underflow_q, underflow_d;

  logic empty, full;
  logic push, pop_req, pop, pop_last, push_last, underflow_set;

  // FIFO status and handshake decode
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign wr_entry = '{lp: s_lp, last: s_last, data: s_data};
  assign head     = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign push      = s_valid && !full;
  assign push_last = push && s_last;
  // FLUSH drains on its own; STREAM only on lane request
  assign pop_req   = ((state_q == ST_STREAM) && lane_data_rqst) || (state_q == ST_FLUSH);
  assign pop       = pop_req && !empty;
  assign pop_last  = pop && head.last;
  // FLUSH waiting on an empty FIFO is not an underflow
  assign underflow_set = (state_q == ST_STREAM) && lane_data_rqst && empty;

  assign s_ready         = !full;
  assign lane_data       = empty ? 8'h00 : head.data;
  assign lane_start_rqst = (state_q == ST_START);
  assign lane_fin_rqst   = (state_q == ST_FIN);
  assign busy            = (state_q != ST_IDLE);
  assign lane_mode_lp    = mode_lp_q;
  assign underflow       = underflow_q;

  // FIFO storage write (no reset needed, pointers qualify contents)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_entry;
    end
  end

  // Pointer, packet count and sticky underflow next-state
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_count_d = pkt_count_q;
    underflow_d = underflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_last && !pop_last) begin
      pkt_count_d = pkt_count_q + CNT_W'(1);
    end else if (pop_last && !push_last) begin
      pkt_count_d = pkt_count_q - CNT_W'(1);
    end
    if (underflow_set) underflow_d = 1'b1;
    if (underflow_clr) underflow_d = 1'b0;
  end

  // Lane sequencing FSM next-state
  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    seen_active_d = seen_active_q;
    mode_lp_d     = mode_lp_q;
    case (state_q)
      ST_IDLE: begin
        // a full FIFO without a complete packet starts cut-through
        if (lane_ready && ((pkt_count_q != '0) || full)) begin
          state_d   = ST_START;
          mode_lp_d = head.lp;
        end
      end
      ST_START: begin
        state_d       = ST_STREAM;
        seen_active_d = 1'b0;
      end
      ST_STREAM: begin
        if (!lane_ready)   state_d = ST_FLUSH;
        else if (pop_last) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!lane_ready) begin
          state_d = ST_IDLE;
        end else if (seen_active_q && !lane_active) begin
          state_d   = ST_GAP;
          gap_cnt_d = inter_pkt_gap;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      ST_FLUSH: begin
        if (pop_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (lane_active &&
        ((state_q == ST_STREAM) || (state_q == ST_FIN) || (state_q == ST_DRAIN))) begin
      seen_active_d = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gap_cnt_q     <= '0;
      seen_active_q <= 1'b0;
      mode_lp_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pkt_count_q   <= '0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      seen_active_q <= seen_active_d;
      mode_lp_q     <= mode_lp_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pkt_count_q   <= pkt_count_d;
      underflow_q   <= underflow_d;
    end
  end

endmodule

// File: tb/tb_dsi_lane_feeder.sv
// Directed bench for dsi_lane_feeder: packet sequencing, gap timing, flush,
// cut-through/underflow and reset behaviour.
module tb_dsi_lane_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_lp;
  logic       s_ready;
  logic       lane_start_rqst;
  logic       lane_fin_rqst;
  logic       lane_mode_lp;
  logic [7:0] lane_data;
  logic       lane_data_rqst;
  logic       lane_active;
  logic       lane_ready;
  logic [7:0] inter_pkt_gap;
  logic       underflow_clr;
  logic       busy;
  logic       underflow;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int fin_cnt = 0;

  dsi_lane_feeder #(.DEPTH_LOG2(6)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_last          (s_last),
    .s_lp            (s_lp),
    .s_ready         (s_ready),
    .lane_start_rqst (lane_start_rqst),
    .lane_fin_rqst   (lane_fin_rqst),
    .lane_mode_lp    (lane_mode_lp),
    .lane_data       (lane_data),
    .lane_data_rqst  (lane_data_rqst),
    .lane_active     (lane_active),
    .lane_ready      (lane_ready),
    .inter_pkt_gap   (inter_pkt_gap),
    .underflow_clr   (underflow_clr),
    .busy            (busy),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  // Pulse counters for start/fin requests
  always @(negedge clk) begin
    if (lane_start_rqst) start_cnt <= start_cnt + 1;
    if (lane_fin_rqst)   fin_cnt   <= fin_cnt + 1;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last, input logic lp);
    check("push_s_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_lp    = lp;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_lp    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    s_valid        = 1'b0;
    s_data         = 8'h00;
    s_last         = 1'b0;
    s_lp           = 1'b0;
    lane_data_rqst = 1'b1;
    lane_active    = 1'b0;
    lane_ready     = 1'b1;
    inter_pkt_gap  = 8'd0;
    underflow_clr  = 1'b0;
    #2;
    check("rst_s_ready",   32'(s_ready),         32'd1);
    check("rst_start",     32'(lane_start_rqst), 32'd0);
    check("rst_fin",       32'(lane_fin_rqst),   32'd0);
    check("rst_mode",      32'(lane_mode_lp),    32'd0);
    check("rst_lane_data", 32'(lane_data),       32'd0);
    check("rst_busy",      32'(busy),            32'd0);
    check("rst_underflow", 32'(underflow),       32'd0);
    check("rst_pkt_count", 32'(dut.pkt_count_q), 32'd0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int sb, fb, n;
    rst_n = 1'b0;
    #1;

    // HS packet A0..A3 streamed back to back
    do_reset();
    sb = start_cnt; fb = fin_cnt;
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA0 + i), (i == 3), 1'b0);
    check("t1_no_start_n1", 32'(lane_start_rqst), 32'd0);
    check("t1_idle_n1",     32'(busy),            32'd0);
    step();
    check("t1_start_n2",  32'(lane_start_rqst), 32'd1);
    check("t1_head_A0",   32'(lane_data),       32'hA0);
    check("t1_mode_hs",   32'(lane_mode_lp),    32'd0);
    step();
    lane_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t1_byte", 32'(lane_data), 32'(8'hA0 + i));
      check("t1_no_fin_yet", 32'(lane_fin_rqst), 32'd0);
      step();
    end
    check("t1_fin",       32'(lane_fin_rqst), 32'd1);
    check("t1_empty_data", 32'(lane_data),    32'd0);
    lane_active = 1'b0;
    step();
    check("t1_fin_one_cycle", 32'(lane_fin_rqst), 32'd0);
    check("t1_drain_busy",    32'(busy),          32'd1);
    step();
    step();
    check("t1_back_idle",   32'(busy),            32'd0);
    check("t1_start_count", 32'(start_cnt - sb),  32'd1);
    check("t1_fin_count",   32'(fin_cnt - fb),    32'd1);
    check("t1_no_underflow", 32'(underflow),      32'd0);

    // LP packet, requests 31 cycles apart
    do_reset();
    sb = start_cnt; fb = fin_cnt;
    push_byte(8'hB0, 1'b0, 1'b1);
    push_byte(8'hB1, 1'b1, 1'b1);
    step();
    check("t2_start",   32'(lane_start_rqst), 32'd1);
    check("t2_mode_lp", 32'(lane_mode_lp),    32'd1);
    step();
    lane_data_rqst = 1'b0;
    check("t2_no_pop_in_start", 32'(lane_data), 32'hB0);
    lane_active = 1'b1;
    step();
    step();
    lane_data_rqst = 1'b1;
    step();
    lane_data_rqst = 1'b0;
    check("t2_second_byte", 32'(lane_data), 32'hB1);
    for (int k = 0; k < 30; k++) step();
    check("t2_mode_held", 32'(lane_mode_lp),  32'd1);
    check("t2_no_fin",    32'(lane_fin_rqst), 32'd0);
    lane_data_rqst = 1'b1;
    step();
    check("t2_fin",        32'(lane_fin_rqst), 32'd1);
    check("t2_mode_at_fin", 32'(lane_mode_lp), 32'd1);
    step();
    lane_ready = 1'b0;
    step();
    check("t2_drain_to_idle", 32'(busy),           32'd0);
    check("t2_start_count",   32'(start_cnt - sb), 32'd1);
    check("t2_fin_count",     32'(fin_cnt - fb),   32'd1);
    lane_ready  = 1'b1;
    lane_active = 1'b0;

    // Two packets back to back, inter_pkt_gap = 10
    do_reset();
    inter_pkt_gap = 8'd10;
    push_byte(8'hC0, 1'b0, 1'b0);
    push_byte(8'hC1, 1'b1, 1'b0);
    push_byte(8'hD0, 1'b0, 1'b1);
    check("t3_start1", 32'(lane_start_rqst), 32'd1);
    check("t3_mode1",  32'(lane_mode_lp),    32'd0);
    push_byte(8'hD1, 1'b1, 1'b1);
    lane_active = 1'b1;
    step();
    step();
    check("t3_fin1",       32'(lane_fin_rqst),   32'd1);
    check("t3_pkt_count1", 32'(dut.pkt_count_q), 32'd1);
    step();
    step();
    lane_active = 1'b0;
    step();
    check("t3_gap_busy",  32'(busy),            32'd1);
    check("t3_gap_mode0", 32'(lane_mode_lp),    32'd0);
    n = 0;
    while (!lane_start_rqst && n < 40) begin
      step();
      n++;
    end
    // edges from the one sampling lane_active low to the one raising start
    check("t3_gap_latency", 32'(n),            32'd12);
    check("t3_mode_switch", 32'(lane_mode_lp), 32'd1);
    lane_active = 1'b1;
    step();
    check("t3_D0", 32'(lane_data), 32'hD0);
    step();
    check("t3_D1", 32'(lane_data), 32'hD1);
    step();
    check("t3_fin2",       32'(lane_fin_rqst),   32'd1);
    check("t3_pkt_count0", 32'(dut.pkt_count_q), 32'd0);
    lane_active = 1'b0;

    // lane_ready drops after 2 of 6 bytes -> FLUSH
    do_reset();
    sb = start_cnt; fb = fin_cnt;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i), (i == 5), 1'b0);
    step();
    check("t4_start", 32'(lane_start_rqst), 32'd1);
    step();
    check("t4_G0", 32'(lane_data), 32'h10);
    step();
    check("t4_G1", 32'(lane_data), 32'h11);
    step();
    lane_ready     = 1'b0;
    lane_data_rqst = 1'b0;
    check("t4_G2_head", 32'(lane_data), 32'h12);
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check("t4_flush_cycles", 32'(n),               32'd5);
    check("t4_pkt_count0",   32'(dut.pkt_count_q), 32'd0);
    check("t4_no_fin",       32'(fin_cnt - fb),    32'd0);
    check("t4_one_start",    32'(start_cnt - sb),  32'd1);
    check("t4_no_underflow", 32'(underflow),       32'd0);
    check("t4_empty_data",   32'(lane_data),       32'd0);
    lane_ready     = 1'b1;
    lane_data_rqst = 1'b1;

    // Fill 64 bytes without s_last: cut-through, then underflow
    do_reset();
    lane_data_rqst = 1'b0;
    for (int i = 0; i < 64; i++) push_byte(8'(i), 1'b0, 1'b0);
    check("t5_full_not_ready", 32'(s_ready), 32'd0);
    check("t5_idle_at_full",   32'(busy),    32'd0);
    step();
    check("t5_cut_through_start", 32'(lane_start_rqst), 32'd1);
    step();
    lane_data_rqst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check("t5_byte", 32'(lane_data), 32'(i));
      step();
      if (i == 0) check("t5_ready_after_pop", 32'(s_ready), 32'd1);
    end
    check("t5_empty_data",    32'(lane_data), 32'd0);
    check("t5_no_underflow",  32'(underflow), 32'd0);
    step();
    check("t5_underflow_set", 32'(underflow), 32'd1);
    underflow_clr = 1'b1;
    step();
    check("t5_clr_wins", 32'(underflow), 32'd0);
    underflow_clr  = 1'b0;
    lane_data_rqst = 1'b0;
    step();
    check("t5_clr_held",  32'(underflow), 32'd0);
    check("t5_streaming", 32'(busy),      32'd1);

    // Reset mid-packet with data in the FIFO
    push_byte(8'h55, 1'b0, 1'b0);
    do_reset();
    check("t6_post_reset_data", 32'(lane_data), 32'd0);
    check("t6_post_reset_busy", 32'(busy),      32'd0);

    // Push of pkt2 last coincides with pop of pkt1 last
    push_byte(8'hE0, 1'b0, 1'b0);
    push_byte(8'hE1, 1'b1, 1'b0);
    step();
    check("t7_start1", 32'(lane_start_rqst), 32'd1);
    push_byte(8'hF0, 1'b0, 1'b0);
    lane_active = 1'b1;
    step();
    s_valid = 1'b1;
    s_data  = 8'hF1;
    s_last  = 1'b1;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("t7_pkt_count_held", 32'(dut.pkt_count_q), 32'd1);
    check("t7_fin",            32'(lane_fin_rqst),   32'd1);
    step();
    lane_active = 1'b0;
    step();
    check("t7_gap_busy",    32'(busy),            32'd1);
    check("t7_gap_nostart", 32'(lane_start_rqst), 32'd0);
    step();
    check("t7_idle", 32'(busy), 32'd0);
    step();
    check("t7_start2", 32'(lane_start_rqst), 32'd1);
    check("t7_head_F0", 32'(lane_data),      32'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
